// File: rtl/serial_sub16.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Operands shift right through the datapath; results only reach the outputs on completion.
module serial_sub16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d, bout_q, bout_d, ovf_q, ovf_d;
  logic             bit_d, brw_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    bit_d   = a_q[0] ^ b_q[0] ^ brw_q;
    brw_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          res_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
        end
      end
      S_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {bit_d, res_q[WIDTH-1:1]};
        brw_d = brw_nxt;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          // a_q[0]/b_q[0] now hold the original sign bits
          state_d = S_DONE;
          diff_d  = {bit_d, res_q[WIDTH-1:1]};
          bout_d  = brw_nxt;
          ovf_d   = (a_q[0] != b_q[0]) && (bit_d != a_q[0]);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign diff     = diff_q;
  assign bout     = bout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_sub16.sv
// Self-checking bench for serial_sub16: directed cases plus random operands
// compared against an arithmetic reference model.
module tb_serial_sub16;

  logic        clk = 1'b0;
  logic        rst, start, bin;
  logic [15:0] a, b;
  logic        busy, done, bout, overflow;
  logic [15:0] diff;

  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0] last_diff;

  serial_sub16 #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // {bout, overflow, diff} from plain integer arithmetic
  function automatic logic [17:0] model(input logic [15:0] av, input logic [15:0] bv,
                                        input logic bi);
    logic [16:0] r;
    int          sd;
    r  = {1'b0, av} - {1'b0, bv} - {16'd0, bi};
    sd = int'($signed(av)) - int'($signed(bv)) - int'(bi);
    return {r[16], (sd > 32767 || sd < -32768), r[15:0]};
  endfunction

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] av,
                              input logic [15:0] bv, input logic bi, input int cyc);
    logic [17:0] m;
    m = model(av, bv, bi);
    chk({tag, "_lat"},  cyc, 16);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_diff"}, diff, m[15:0]);
    chk({tag, "_bout"}, bout, m[17]);
    chk({tag, "_ovf"},  overflow, m[16]);
    last_diff = m[15:0];
  endtask

  // Called #1 after a rising edge; leaves the bench in the DONE cycle.
  task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic bi);
    int cyc;
    a = av; b = bv; bin = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
    chk({tag, "_busy"}, busy, 1'b1);
    wait_done(cyc);
    check_result(tag, av, bv, bi, cyc);
  endtask

  task automatic idle_chk(input string tag);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, done, 1'b0);
    chk({tag, "_hold"},  diff, last_diff);
  endtask

  initial begin
    int cyc, seen;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    last_diff = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_diff", diff, 16'h0);
    chk("rst_bout", bout, 1'b0);
    chk("rst_ovf",  overflow, 1'b0);

    // reset wins over a simultaneous start
    start = 1'b1; a = 16'd9; b = 16'd5;
    @(posedge clk); #1;
    chk("rst_prio_busy", busy, 1'b0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;

    do_op("t1", 16'd9, 16'd5, 1'b1);
    idle_chk("t1");
    do_op("t2", 16'd5, 16'd9, 1'b0);
    idle_chk("t2");
    do_op("t3", 16'h8000, 16'h0001, 1'b0);
    idle_chk("t3");
    do_op("t4", 16'h7FFF, 16'hFFFF, 1'b0);
    idle_chk("t4");

    // start during RUN is ignored
    a = 16'd9; b = 16'd5; bin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    a = 16'd0; b = 16'd0; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc);
    check_result("t5a", 16'd9, 16'd5, 1'b1, cyc + 3);
    idle_chk("t5a");

    // reset mid-run aborts with no done pulse
    a = 16'd9; b = 16'd5; bin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5b_busy", busy, 1'b0);
    chk("t5b_diff", diff, 16'h0);
    chk("t5b_bout", bout, 1'b0);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    chk("t5b_no_done", seen, 0);
    do_op("t5c", 16'd1234, 16'd4321, 1'b0);

    // back-to-back start in the DONE cycle
    chk("t6_in_done", done, 1'b1);
    do_op("t6", 16'd49152, 16'd49152, 1'b1);
    idle_chk("t6");

    for (int i = 0; i < 24; i++) begin
      do_op("rnd", 16'($urandom), 16'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 0) idle_chk("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
